// File: rtl/ntt_stage_sched_pkg.sv
// Shared types and default sizing for the NTT stage scheduler.
// The defaults are reused by the address/RAM logic and the butterfly unit.
package ntt_stage_sched_pkg;

    localparam int DEFAULT_RING_LOG2 = 8;
    localparam int DEFAULT_BFU_LAT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ntt_stage_sched_if.sv
// Control/address bundle between the NTT scheduler and the datapath that consumes it.
// The master drives start/hold; the slave (scheduler) drives everything else.
interface ntt_stage_sched_if
    import ntt_stage_sched_pkg::*;
#(
    parameter int RING_LOG2 = DEFAULT_RING_LOG2
);
    logic                 start;
    logic                 hold;
    logic                 busy;
    logic                 done;
    logic [RING_LOG2-1:0] stage;
    logic                 rd_en;
    logic [RING_LOG2-1:0] rd_addr_0;
    logic [RING_LOG2-1:0] rd_addr_1;
    logic [RING_LOG2-1:0] tw_addr;
    logic                 rd_bank;
    logic                 wr_en;
    logic [RING_LOG2-1:0] wr_addr_0;
    logic [RING_LOG2-1:0] wr_addr_1;
    logic                 wr_bank;
    logic                 result_bank;

    modport master (
        output start, hold,
        input  busy, done, stage, rd_en, rd_addr_0, rd_addr_1, tw_addr, rd_bank,
        input  wr_en, wr_addr_0, wr_addr_1, wr_bank, result_bank
    );

    modport slave (
        input  start, hold,
        output busy, done, stage, rd_en, rd_addr_0, rd_addr_1, tw_addr, rd_bank,
        output wr_en, wr_addr_0, wr_addr_1, wr_bank, result_bank
    );
endinterface

// File: rtl/ntt_wb_delay.sv
// Fixed-depth shift pipe carrying a valid bit plus payload; clearable by reset, never stalls.
module ntt_wb_delay #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH:0] pipe_q [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pipe
        logic [WIDTH:0] pipe_d;
        if (gi == 0) begin : g_head
            assign pipe_d = {valid_i, data_i};
        end else begin : g_tail
            assign pipe_d = pipe_q[gi-1];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                pipe_q[gi] <= '0;
            end else begin
                pipe_q[gi] <= pipe_d;
            end
        end
    end

    assign {valid_o, data_o} = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sched.sv
// Stage sequencer for the in-place Cooley-Tukey NTT: issues butterfly reads stage by
// stage, delays write-back addresses through the BFU latency and drains between stages.
module ntt_stage_sched
    import ntt_stage_sched_pkg::*;
#(
    parameter int RING_LOG2 = DEFAULT_RING_LOG2,
    parameter int BFU_LAT   = DEFAULT_BFU_LAT
) (
    input  logic              clk,
    input  logic              reset,
    ntt_stage_sched_if.slave  bus
);

    localparam int R  = RING_LOG2;
    localparam int DW = (BFU_LAT > 1) ? $clog2(BFU_LAT) : 1;

    localparam logic [R-1:0]  ONE         = R'(1);
    localparam logic [R-1:0]  HALF0       = ONE << (R - 1);
    localparam logic [R-1:0]  LAST_BFLY   = HALF0 - ONE;
    localparam logic [R-1:0]  FINAL_STAGE = R'(R - 1);
    localparam logic [DW-1:0] DRAIN_LAST  = DW'(BFU_LAT - 1);
    localparam logic          RESULT_BANK = 1'(RING_LOG2 % 2);

    state_t        state_q;
    logic [R-1:0]  stage_q;
    logic [R-1:0]  cnt_q;
    logic [R-1:0]  o_q;
    logic [R-1:0]  base_q;
    logic [R-1:0]  half_q;
    logic [R-1:0]  tw_q;
    logic [R-1:0]  tw_base_q;
    logic [DW-1:0] drain_q;
    logic          rd_bank_q;
    logic          busy_q;
    logic          done_q;
    logic          result_bank_q;

    logic          issue;
    logic          o_wrap;
    logic [R-1:0]  o_inc;
    logic [R-1:0]  o_d;
    logic [R-1:0]  base_d;
    logic [R-1:0]  tw_d;
    logic [R-1:0]  rd_addr_0_w;
    logic [R-1:0]  rd_addr_1_w;
    logic          wb_valid;
    logic [2*R-1:0] wb_data;

    // base_q tracks g*2*half so addresses need only adds; the tw index advances with g.
    assign issue       = (state_q == ST_ISSUE) && !bus.hold;
    assign o_inc       = o_q + ONE;
    assign o_wrap      = (o_inc == half_q);
    assign o_d         = o_wrap ? '0 : o_inc;
    assign base_d      = o_wrap ? base_q + (half_q << 1) : base_q;
    assign tw_d        = o_wrap ? tw_q + ONE : tw_q;
    assign rd_addr_0_w = base_q + o_q;
    assign rd_addr_1_w = base_q + o_q + half_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            stage_q       <= '0;
            cnt_q         <= '0;
            o_q           <= '0;
            base_q        <= '0;
            half_q        <= '0;
            tw_q          <= '0;
            tw_base_q     <= '0;
            drain_q       <= '0;
            rd_bank_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_bank_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q       <= ST_ISSUE;
                        stage_q       <= '0;
                        cnt_q         <= '0;
                        o_q           <= '0;
                        base_q        <= '0;
                        half_q        <= HALF0;
                        tw_q          <= ONE;
                        tw_base_q     <= ONE;
                        rd_bank_q     <= 1'b0;
                        busy_q        <= 1'b1;
                        result_bank_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (!bus.hold) begin
                        o_q    <= o_d;
                        base_q <= base_d;
                        tw_q   <= tw_d;
                        cnt_q  <= cnt_q + ONE;
                        if (cnt_q == LAST_BFLY) begin
                            state_q <= ST_DRAIN;
                            drain_q <= DRAIN_LAST;
                        end
                    end
                end
                ST_DRAIN: begin
                    // drain_q reaching zero marks the cycle carrying the stage's last write.
                    if (drain_q == '0) begin
                        if (stage_q == FINAL_STAGE) begin
                            state_q       <= ST_DONE;
                            busy_q        <= 1'b0;
                            done_q        <= 1'b1;
                            result_bank_q <= RESULT_BANK;
                        end else begin
                            state_q   <= ST_ISSUE;
                            stage_q   <= stage_q + ONE;
                            rd_bank_q <= ~rd_bank_q;
                            cnt_q     <= '0;
                            o_q       <= '0;
                            base_q    <= '0;
                            half_q    <= half_q >> 1;
                            tw_q      <= tw_base_q << 1;
                            tw_base_q <= tw_base_q << 1;
                        end
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ntt_wb_delay #(
        .DEPTH (BFU_LAT),
        .WIDTH (2 * R)
    ) u_wb_delay (
        .clk     (clk),
        .reset   (reset),
        .valid_i (issue),
        .data_i  ({rd_addr_0_w, rd_addr_1_w}),
        .valid_o (wb_valid),
        .data_o  (wb_data)
    );

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.stage       = stage_q;
    assign bus.rd_en       = issue;
    assign bus.rd_addr_0   = rd_addr_0_w;
    assign bus.rd_addr_1   = rd_addr_1_w;
    assign bus.tw_addr     = tw_q;
    assign bus.rd_bank     = rd_bank_q;
    assign bus.wr_en       = wb_valid;
    assign bus.wr_addr_0   = wb_data[2*R-1:R];
    assign bus.wr_addr_1   = wb_data[R-1:0];
    assign bus.wr_bank     = ~rd_bank_q;
    assign bus.result_bank = result_bank_q;

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Bench for ntt_stage_sched: N=8 scenario table with a write-back scoreboard,
// a reset-abort sequence, and a full default-size run against a formula model.
module tb_ntt_stage_sched;

    localparam int R  = 3;
    localparam int L  = 2;
    localparam int BR = 8;
    localparam int BL = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ntt_stage_sched_if #(.RING_LOG2(R))  bus_s ();
    ntt_stage_sched_if #(.RING_LOG2(BR)) bus_b ();

    ntt_stage_sched #(.RING_LOG2(R), .BFU_LAT(L)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    ntt_stage_sched #(.RING_LOG2(BR), .BFU_LAT(BL)) u_dut_big (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int a0; int a1; int tw; int stg; int bank; } rd_exp_t;
    typedef struct { int a0; int a1; int bank; int due; } wr_exp_t;
    typedef struct { int hold_at; int hold_len; int start_a; int start_b; int done_k; int res_bank; } scen_t;

    rd_exp_t rd_tab [12];
    scen_t   scen_tab [5];
    wr_exp_t wr_q [$];
    wr_exp_t w_pop;
    logic    mon_en = 1'b0;
    int      rd_idx = 0;

    // Small-DUT monitor: reads follow the expected table, writes are popped from the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_s.rd_en) begin
                if (rd_idx < 12) begin
                    check("rd_addr_0", bus_s.rd_addr_0, rd_tab[rd_idx].a0);
                    check("rd_addr_1", bus_s.rd_addr_1, rd_tab[rd_idx].a1);
                    check("tw_addr", bus_s.tw_addr, rd_tab[rd_idx].tw);
                    check("stage", bus_s.stage, rd_tab[rd_idx].stg);
                    check("rd_bank", bus_s.rd_bank, rd_tab[rd_idx].bank);
                    wr_q.push_back(wr_exp_t'{rd_tab[rd_idx].a0, rd_tab[rd_idx].a1,
                                             1 - rd_tab[rd_idx].bank, cyc + L});
                end else begin
                    check("extra_rd", bus_s.rd_en, 0);
                end
                rd_idx++;
            end
            if (bus_s.wr_en) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", bus_s.wr_en, 0);
                end else begin
                    w_pop = wr_q.pop_front();
                    check("wr_addr_0", bus_s.wr_addr_0, w_pop.a0);
                    check("wr_addr_1", bus_s.wr_addr_1, w_pop.a1);
                    check("wr_bank", bus_s.wr_bank, w_pop.bank);
                    check("wr_time", cyc, w_pop.due);
                end
            end
        end
    end

    // Default-size monitor: every read checked against the g*2*half+o formula.
    logic big_en    = 1'b0;
    int   big_s     = 0;
    int   big_b     = 0;
    int   big_first = -1;
    int   big_wr    = 0;
    always @(negedge clk) begin
        if (big_en) begin
            if (bus_b.rd_en) begin
                automatic int half = 256 >> (big_s + 1);
                automatic int g    = big_b / half;
                automatic int o    = big_b % half;
                automatic int a0   = g * 2 * half + o;
                if (big_first < 0) big_first = cyc;
                check("big_rd", {bus_b.stage, bus_b.rd_addr_0, bus_b.rd_addr_1, bus_b.tw_addr},
                      {8'(big_s), 8'(a0), 8'(a0 + half), 8'((1 << big_s) + g)});
                if (big_s == 0 && big_b == 127) begin
                    check("big_s0_b127_a0", bus_b.rd_addr_0, 127);
                    check("big_s0_b127_a1", bus_b.rd_addr_1, 255);
                    check("big_s0_b127_tw", bus_b.tw_addr, 1);
                end
                if (big_s == 7 && big_b == 5) begin
                    check("big_s7_b5_a0", bus_b.rd_addr_0, 10);
                    check("big_s7_b5_a1", bus_b.rd_addr_1, 11);
                    check("big_s7_b5_tw", bus_b.tw_addr, 133);
                end
                big_b++;
                if (big_b == 128) begin
                    big_b = 0;
                    big_s++;
                end
            end
            if (bus_b.wr_en) big_wr++;
        end
    end

    task automatic pulse_start_small();
        @(posedge clk); #1;
        bus_s.start = 1'b1;
        @(posedge clk); #1;
        bus_s.start = 1'b0;
    endtask

    task automatic run_scen(input int i);
        scen_t sc;
        sc = scen_tab[i];
        rd_idx = 0;
        wr_q.delete();
        mon_en = 1'b1;
        pulse_start_small();
        for (int k = 0; k < 40; k++) begin
            bus_s.hold  = (k >= sc.hold_at) && (k < sc.hold_at + sc.hold_len);
            bus_s.start = (k == sc.start_a) || (k == sc.start_b);
            @(negedge clk);
            if (k == 0) check("first_rd_en", bus_s.rd_en, 1);
            check("busy", bus_s.busy, k < sc.done_k);
            check("done", bus_s.done, k == sc.done_k);
            if (k == sc.done_k) check("result_bank", bus_s.result_bank, sc.res_bank);
            @(posedge clk); #1;
        end
        bus_s.hold  = 1'b0;
        bus_s.start = 1'b0;
        check("rd_count", rd_idx, 12);
        check("wr_pending", wr_q.size(), 0);
        mon_en = 1'b0;
        $display("scenario %0d: hold@%0d x%0d, extra start %0d/%0d, done expected at +%0d",
                 i, sc.hold_at, sc.hold_len, sc.start_a, sc.start_b, sc.done_k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_tab[0]  = '{0, 4, 1, 0, 0};
        rd_tab[1]  = '{1, 5, 1, 0, 0};
        rd_tab[2]  = '{2, 6, 1, 0, 0};
        rd_tab[3]  = '{3, 7, 1, 0, 0};
        rd_tab[4]  = '{0, 2, 2, 1, 1};
        rd_tab[5]  = '{1, 3, 2, 1, 1};
        rd_tab[6]  = '{4, 6, 3, 1, 1};
        rd_tab[7]  = '{5, 7, 3, 1, 1};
        rd_tab[8]  = '{0, 1, 4, 2, 0};
        rd_tab[9]  = '{2, 3, 5, 2, 0};
        rd_tab[10] = '{4, 5, 6, 2, 0};
        rd_tab[11] = '{6, 7, 7, 2, 0};

        // {hold_at, hold_len, start_a, start_b, done_k, result_bank}
        scen_tab[0] = '{-1, 0, -1, -1, 18, 1};  // plain run
        scen_tab[1] = '{ 8, 3, -1, -1, 21, 1};  // hold mid stage 1
        scen_tab[2] = '{-1, 0,  5, 18, 18, 1};  // start while busy and in DONE
        scen_tab[3] = '{ 3, 2, -1, -1, 20, 1};  // hold on last issue of stage 0
        scen_tab[4] = '{ 4, 2, -1, -1, 18, 1};  // hold during DRAIN is ignored

        bus_s.start = 1'b0;
        bus_s.hold  = 1'b0;
        bus_b.start = 1'b0;
        bus_b.hold  = 1'b0;
        reset       = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus_s.busy, 0);
        check("rst_done", bus_s.done, 0);
        check("rst_rd_en", bus_s.rd_en, 0);
        check("rst_wr_en", bus_s.wr_en, 0);
        check("rst_stage", bus_s.stage, 0);
        check("rst_addrs", {bus_s.rd_addr_0, bus_s.rd_addr_1, bus_s.tw_addr,
                            bus_s.wr_addr_0, bus_s.wr_addr_1}, 0);
        check("rst_rd_bank", bus_s.rd_bank, 0);
        check("rst_wr_bank", bus_s.wr_bank, 1);
        check("rst_result_bank", bus_s.result_bank, 0);
        check("rst_big_wr_bank", bus_b.wr_bank, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_scen(i);

        // Reset in stage 1 with two writes still in flight.
        rd_idx = 0;
        wr_q.delete();
        mon_en = 1'b1;
        pulse_start_small();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_stage", bus_s.stage, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b0;
        @(negedge clk);
        check("abort_wr_en", bus_s.wr_en, 0);
        check("abort_busy", bus_s.busy, 0);
        check("abort_stage", bus_s.stage, 0);
        check("abort_rd_en", bus_s.rd_en, 0);
        for (int k = 0; k < 12; k++) begin
            check("abort_no_done", bus_s.done, 0);
            check("abort_no_wr", bus_s.wr_en, 0);
            @(negedge clk);
        end
        wr_q.delete();
        $display("reset abort in stage 1 checked");
        run_scen(0);

        // Default-size transform.
        big_en = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        begin
            int done_cyc;
            done_cyc = -1;
            for (int k = 0; k < 1200 && done_cyc < 0; k++) begin
                @(negedge clk);
                if (bus_b.done) begin
                    done_cyc = cyc;
                    check("big_result_bank", bus_b.result_bank, 0);
                end
                @(posedge clk); #1;
            end
            if (done_cyc < 0) check("big_done_seen", bus_b.done, 1);
            else check("big_done_time", done_cyc - big_first, 1056);
        end
        repeat (4) @(posedge clk);
        #1;
        check("big_rd_stages", big_s, 8);
        check("big_wr_count", big_wr, 1024);
        big_en = 1'b0;
        $display("default-size transform: %0d writes observed", big_wr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_stage_sched.md
Name: ntt_stage_sched

Overview:
- Top-level sequencer for the in-place Cooley-Tukey NTT datapath.
- After a start pulse it walks all log2(N) stages. In each stage it issues one butterfly pair per cycle: read addresses, twiddle index and ping-pong bank select.
- It delays each write-back address through the fixed BFU pipeline latency, so writes line up with the butterfly outputs.
- It drains the pipeline between stages, so a stage never reads a bank that is still being written. It signals done when the result sits in the final bank.

Parameters:
- RING_LOG2, 8, log2 of ring size N (N = 256 by default); also the number of stages.
- BFU_LAT, 4, cycles from rd_en to the matching wr_en (RAM read plus butterfly pipeline); must be at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transform; accepted only in IDLE.
- hold  in  1  stalls issue in ISSUE state (RAM port contention); ignored in other states.
- busy  out  1  high from the cycle after start is accepted until the done cycle, exclusive.
- done  out  1  one-cycle pulse when the final write has been issued.
- stage  out  RING_LOG2  current stage index s, 0..RING_LOG2-1.
- rd_en  out  1  a butterfly read is issued this cycle.
- rd_addr_0  out  RING_LOG2  top operand address.
- rd_addr_1  out  RING_LOG2  bottom operand address.
- tw_addr  out  RING_LOG2  twiddle ROM index.
- rd_bank  out  1  bank being read: 0 selects ram0/ram1, 1 selects ram2/ram3.
- wr_en  out  1  write-back valid.
- wr_addr_0  out  RING_LOG2  top write address (rd_addr_0 delayed by BFU_LAT).
- wr_addr_1  out  RING_LOG2  bottom write address (rd_addr_1 delayed by BFU_LAT).
- wr_bank  out  1  bank being written; always ~rd_bank.
- result_bank  out  1  bank that holds the finished transform; held until the next start is accepted.

Behaviour:
- Reset: state goes to IDLE; all valid bits in the delay pipe are cleared.
  - Reset values are 0 for busy, done, rd_en, wr_en, stage, all addresses, rd_bank and result_bank; wr_bank resets to 1.
  - Reset mid-transform aborts immediately: no further wr_en, and no done pulse.
- FSM states: IDLE -> ISSUE -> DRAIN -> (ISSUE or DONE) -> IDLE.
  - IDLE: when start=1, clear stage, group g and offset o, set rd_bank=0, then enter ISSUE.
  - ISSUE: each cycle with hold=0, assert rd_en and advance (g,o). Let half = N >> (s+1).
    - rd_addr_0 = g*2*half + o; rd_addr_1 = rd_addr_0 + half; tw_addr = (1<<s) + g.
    - Compute addresses with counters only (shifts/adds, no divider). o counts 0..half-1, then wraps and increments g.
    - After butterfly N/2-1 of the stage has issued, go to DRAIN.
    - With hold=1: rd_en=0 and counters are frozen, but the delay pipe keeps advancing.
  - DRAIN: rd_en=0. Exit at the end of the cycle in which the last wr_en of the stage is asserted.
    - If s < RING_LOG2-1: increment stage, toggle rd_bank, reset g and o, go to ISSUE.
    - Otherwise go to DONE.
  - DONE: one cycle. done=1, busy=0, result_bank = RING_LOG2[0]; then go to IDLE.
- Timing with hold=0: the first rd_en is in the cycle after start is sampled. Each stage lasts N/2 + BFU_LAT cycles. done is asserted exactly RING_LOG2*(N/2+BFU_LAT) cycles after the first rd_en cycle.
- Delay pipe: BFU_LAT stages of {valid, addr_0, addr_1}. wr_en in cycle t+BFU_LAT corresponds exactly to rd_en in cycle t.
- start is ignored while busy or in DONE. No event is queued.
- hold arriving in the same cycle as the last issue of a stage: that issue is deferred until hold drops. The stage does not end early.

Decomposition:
- define.v holds Ringsize, Stage and the BFU latency default, shared with the address/RAM logic and the BFU.
- The FSM state encoding is localparam inside this module.
- One sub-module, ntt_wb_delay: a parameterised shift pipe (DEPTH, WIDTH) carrying valid plus the two addresses. It is reset-clearable and has no stall input.

Test Plan:
- N=8 (RING_LOG2=3), BFU_LAT=2, start, no hold -> expected response:
  - Stage 0 reads (0,4),(1,5),(2,6),(3,7) with tw 1,1,1,1.
  - Stage 1 reads (0,2),(1,3),(4,6),(5,7) with tw 2,2,3,3.
  - Stage 2 reads (0,1),(2,3),(4,5),(6,7) with tw 4,5,6,7.
  - rd_bank goes 0,1,0; done comes 18 cycles after the first rd_en; result_bank=1.
- Default N=256, BFU_LAT=4 -> expected response:
  - Stage 0, b=127 gives addresses (127,255), tw 1.
  - Stage 7, b=5 gives addresses (10,11), tw 133.
  - done comes 1056 cycles after the first rd_en; result_bank=0.
- N=8, hold=1 for 3 cycles in the middle of stage 1 -> expected response:
  - Address sequence is unchanged.
  - done comes exactly 3 cycles later than in the first scenario.
  - wr_en continues during the hold until the pipe empties.
- Every wr_en is checked against the rd_en from BFU_LAT cycles earlier -> addresses must match, and wr_bank must equal ~rd_bank of the issuing stage.
- start pulsed again while busy -> no restart, unchanged done time, and exactly one done pulse.
- reset asserted in stage 1 with the pipe full -> expected response:
  - Next cycle: wr_en=0, busy=0, stage=0, no done.
  - A fresh start then reproduces the first scenario exactly.
